// File: rtl/rhd_spi_responder_if.sv
// rtl/rhd_spi_responder_if.sv - CS/SCLK/MOSI/MISO link between an RHD controller and the chip-side responder
interface rhd_spi_responder_if;
  logic CS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output CS, output SCLK, output MOSI, input MISO);
  modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/rhd_spi_responder.sv
// rtl/rhd_spi_responder.sv - RHD2000-style SPI slave returning results with a 2-frame pipeline latency
// Define RHD_RESP_ERRCNT_EN to add err_count (aborted frames and SCLK setup violations).
module rhd_spi_responder #(
  parameter int NUM_CH     = 32,
  parameter int CHIP_ID    = 1,
  parameter int MISO_DELAY = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  rhd_spi_responder_if.slave  spi,
  output logic                frame_done,
  output logic [15:0]         last_cmd
`ifdef RHD_RESP_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  localparam logic [6:0] NUM_CH_W  = 7'(NUM_CH);
  localparam logic [5:0] LAST_CH   = 6'(NUM_CH - 1);
  localparam logic [7:0] NUM_CH_B  = 8'(NUM_CH);
  localparam logic [7:0] CHIP_ID_B = 8'(CHIP_ID);

  logic [1:0]  state;
  logic [1:0]  cs_sync, sclk_sync, mosi_sync;
  logic        cs_q, sclk_q;
  logic        cs_s, sclk_rise, sclk_fall, cs_rise;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_sr, tx_sr, tx_word, pend;
  logic        miso_r;
  logic [9:0]  conv_cnt;
  logic [7:0]  regs [0:21];
  logic [5:0]  addr;
  logic [7:0]  rd_val;
  logic [15:0] result;

  // CS resets high so the synchronizer never fakes a frame start out of reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi.CS};
      sclk_sync <= {sclk_sync[0], spi.SCLK};
      mosi_sync <= {mosi_sync[0], spi.MOSI};
      cs_q      <= cs_sync[1];
      sclk_q    <= sclk_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign cs_rise   = cs_s && !cs_q;
  assign sclk_rise = !cs_s && sclk_sync[1] && !sclk_q;
  assign sclk_fall = !cs_s && !sclk_sync[1] && sclk_q;
  assign addr      = rx_sr[13:8];

  always_comb begin
    rd_val = 8'h00;
    if (addr <= 6'd21) begin
      rd_val = regs[addr[4:0]];
    end else begin
      case (addr)
        6'd40:   rd_val = 8'h49;
        6'd41:   rd_val = 8'h4E;
        6'd42:   rd_val = 8'h54;
        6'd43:   rd_val = 8'h41;
        6'd44:   rd_val = 8'h4E;
        6'd60:   rd_val = 8'h01;
        6'd62:   rd_val = NUM_CH_B;
        6'd63:   rd_val = CHIP_ID_B;
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_comb begin
    result = 16'h0000;
    case (rx_sr[15:14])
      2'b00:   if ({1'b0, addr} < NUM_CH_W) result = {addr, conv_cnt};
      2'b10:   result = {8'hFF, rx_sr[7:0]};
      2'b11:   result = {8'h00, rd_val};
      default: result = 16'h0000;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      bit_cnt    <= 5'd0;
      rx_sr      <= 16'h0000;
      tx_sr      <= 16'h0000;
      tx_word    <= 16'h0000;
      pend       <= 16'h0000;
      miso_r     <= 1'b0;
      last_cmd   <= 16'h0000;
      frame_done <= 1'b0;
      conv_cnt   <= 10'd0;
      for (int i = 0; i < 22; i++) regs[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // level test so a CS fall that landed during DECODE is still honoured
          if (!cs_s) begin
            state   <= ST_SHIFT;
            bit_cnt <= 5'd0;
            tx_sr   <= tx_word;
            miso_r  <= tx_word[15];
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            miso_r <= 1'b0;
            state  <= (bit_cnt == 5'd16) ? ST_DECODE : ST_IDLE;
          end else if (sclk_rise) begin
            rx_sr <= {rx_sr[14:0], mosi_sync[1]};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end else if (sclk_fall) begin
            tx_sr  <= {tx_sr[14:0], 1'b0};
            miso_r <= tx_sr[14];
          end
        end
        ST_DECODE: begin
          tx_word    <= pend;
          pend       <= result;
          last_cmd   <= rx_sr;
          frame_done <= 1'b1;
          state      <= ST_IDLE;
          if (rx_sr[15:14] == 2'b10 && addr <= 6'd21) regs[addr[4:0]] <= rx_sr[7:0];
          if (rx_sr[15:14] == 2'b00 && addr == LAST_CH) conv_cnt <= conv_cnt + 10'd1;
          if (rx_sr == 16'h6A00) conv_cnt <= 10'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (MISO_DELAY > 0) begin : g_miso_dly
      logic [MISO_DELAY-1:0] dly;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) dly <= '0;
        else          dly <= MISO_DELAY'({dly, miso_r});
      end
      assign spi.MISO = dly[MISO_DELAY-1];
    end else begin : g_miso_direct
      assign spi.MISO = miso_r;
    end
  endgenerate

`ifdef RHD_RESP_ERRCNT_EN
  logic [1:0] setup_cnt;
  logic       abort_evt, setup_evt;

  assign abort_evt = (state == ST_SHIFT) && cs_rise && (bit_cnt != 5'd16);
  assign setup_evt = sclk_rise && (setup_cnt < 2'd2);

  // setup_cnt counts aclk cycles since synced CS went low
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      setup_cnt <= 2'd0;
      err_count <= 8'd0;
    end else begin
      if (cs_s)                   setup_cnt <= 2'd0;
      else if (setup_cnt != 2'd3) setup_cnt <= setup_cnt + 2'd1;
      if ((abort_evt || setup_evt) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rhd_spi_responder.sv
// tb/tb_rhd_spi_responder.sv - self-checking bench for rhd_spi_responder (MISO_DELAY 0 and 3 instances side by side)
module tb_rhd_spi_responder;
  localparam int NUM_CH  = 32;
  localparam int CHIP_ID = 1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        fd0, fd3;
  logic [15:0] lc0, lc3;
`ifdef RHD_RESP_ERRCNT_EN
  logic [7:0]  ec0, ec3;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt0 = 0, fd_cnt3 = 0;

  always #5 aclk = ~aclk;

  rhd_spi_responder_if bus0();
  rhd_spi_responder_if bus3();
  assign bus0.CS = cs;   assign bus0.SCLK = sclk;   assign bus0.MOSI = mosi;
  assign bus3.CS = cs;   assign bus3.SCLK = sclk;   assign bus3.MOSI = mosi;

  rhd_spi_responder #(.NUM_CH(NUM_CH), .CHIP_ID(CHIP_ID), .MISO_DELAY(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .spi(bus0), .frame_done(fd0), .last_cmd(lc0)
`ifdef RHD_RESP_ERRCNT_EN
    , .err_count(ec0)
`endif
  );
  rhd_spi_responder #(.NUM_CH(NUM_CH), .CHIP_ID(CHIP_ID), .MISO_DELAY(3)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .spi(bus3), .frame_done(fd3), .last_cmd(lc3)
`ifdef RHD_RESP_ERRCNT_EN
    , .err_count(ec3)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (fd0) fd_cnt0++;
    if (fd3) fd_cnt3++;
  end

  // delayed instance must reproduce the direct instance's MISO exactly 3 aclk later
  logic [2:0] hist = 3'b000;
  always @(negedge aclk) begin
    if (!aresetn) begin
      hist = 3'b000;
    end else begin
      checks++;
      if (bus3.MISO !== hist[2]) begin
        errors++;
        $display("FAIL miso_lag at %0t: got %b, expected %b", $time, bus3.MISO, hist[2]);
      end
      hist = {hist[1:0], bus0.MISO};
    end
  end

  // ---------------- reference model ----------------
  int          m_regs [22];
  int          m_conv;
  logic [15:0] m_pipe [$];
  logic [15:0] m_last;
  int          m_aborts;

  function automatic void model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_conv   = 0;
    m_pipe   = {16'h0000, 16'h0000};
    m_last   = 16'h0000;
    m_aborts = 0;
  endfunction

  function automatic logic [15:0] model_exec(input logic [15:0] cmd);
    int    a = int'(cmd[13:8]);
    int    v = 0;
    string id = "INTAN";
    logic [15:0] r = 16'h0000;
    case (cmd[15:14])
      2'b00: if (a < NUM_CH) begin
        r = 16'(a * 1024 + m_conv);
        if (a == NUM_CH - 1) m_conv = (m_conv + 1) % 1024;
      end
      2'b10: begin
        if (a <= 21) m_regs[a] = int'(cmd[7:0]);
        r = {8'hFF, cmd[7:0]};
      end
      2'b11: begin
        if (a <= 21)                v = m_regs[a];
        else if (a >= 40 && a <= 44) v = int'(id[a-40]);
        else if (a == 60)           v = 1;
        else if (a == 62)           v = NUM_CH;
        else if (a == 63)           v = CHIP_ID;
        r = 16'(v);
      end
      default: if (cmd == 16'h6A00) m_conv = 0;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nbits, input int half,
                          output logic [15:0] w0, output logic [15:0] w3);
    w0 = 16'h0; w3 = 16'h0;
    cs = 1'b0; mosi = cmd[15];
    cyc(8);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) begin
        w0[15-i] = bus0.MISO;
        w3[15-i] = bus3.MISO;
      end
      sclk = 1'b1; cyc(half);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? cmd[14-i] : 1'b0;
      cyc(half);
    end
    cs = 1'b1; mosi = 1'b0;
    cyc(8);
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits, input int half,
                           input bit chk_miso, output logic [15:0] w0);
    int f0 = fd_cnt0, f3 = fd_cnt3;
    logic [15:0] w3, exp;
    do_frame(cmd, nbits, half, w0, w3);
    if (nbits == 16) begin
      exp = m_pipe.pop_front();
      m_pipe.push_back(model_exec(cmd));
      m_last = cmd;
      if (chk_miso) begin
        check($sformatf("miso0 cmd=%h", cmd), 32'(w0), 32'(exp));
        check($sformatf("miso3 cmd=%h", cmd), 32'(w3), 32'(exp));
      end
    end else begin
      m_aborts++;
    end
    check($sformatf("frame_done0 n=%0d", nbits), 32'(fd_cnt0 - f0), (nbits == 16) ? 32'd1 : 32'd0);
    check($sformatf("frame_done3 n=%0d", nbits), 32'(fd_cnt3 - f3), (nbits == 16) ? 32'd1 : 32'd0);
    check("last_cmd0", 32'(lc0), 32'(m_last));
    check("last_cmd3", 32'(lc3), 32'(m_last));
  endtask

  task automatic do_reset();
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    aresetn = 1'b0;
    cyc(3);
    check("rst_miso0", 32'(bus0.MISO), 32'd0);
    check("rst_miso3", 32'(bus3.MISO), 32'd0);
    check("rst_frame_done", 32'({fd0, fd3}), 32'd0);
    check("rst_last_cmd", 32'({lc0, lc3}), 32'd0);
`ifdef RHD_RESP_ERRCNT_EN
    check("rst_err_count", 32'({ec0, ec3}), 32'd0);
`endif
    aresetn = 1'b1;
    cyc(3);
    model_reset();
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] miso;
  } vec_t;

  vec_t        tbl [24];
  logic [15:0] w0, w3, cmd;
  int          f0;

  initial begin
    tbl = '{
      '{16'hE800, 16'h0000}, '{16'hE900, 16'h0000}, '{16'hEA00, 16'h0049}, '{16'hEB00, 16'h004E},
      '{16'h842C, 16'h0054}, '{16'hC400, 16'h0041}, '{16'hFF00, 16'hFF2C}, '{16'hFF00, 16'h002C},
      '{16'hFE00, 16'h0001}, '{16'hFC00, 16'h0001}, '{16'hFD00, 16'h0020}, '{16'h5500, 16'h0001},
      '{16'h6A00, 16'h0000}, '{16'hEC00, 16'h0000}, '{16'hD500, 16'h0000}, '{16'hF200, 16'h004E},
      '{16'h955A, 16'h0000}, '{16'hD500, 16'h0000}, '{16'hFF00, 16'hFF5A}, '{16'hFF00, 16'h005A},
      '{16'h9E77, 16'h0001}, '{16'hDE00, 16'h0001}, '{16'hFF00, 16'hFF77}, '{16'hFF00, 16'h0000}
    };

    do_reset();
    for (int i = 0; i < 24; i++) begin
      f0 = fd_cnt0;
      do_frame(tbl[i].cmd, 16, 8, w0, w3);
      check($sformatf("tbl%0d miso0", i), 32'(w0), 32'(tbl[i].miso));
      check($sformatf("tbl%0d miso3", i), 32'(w3), 32'(tbl[i].miso));
      check($sformatf("tbl%0d last_cmd", i), 32'(lc0), 32'(tbl[i].cmd));
      check($sformatf("tbl%0d frame_done", i), 32'(fd_cnt0 - f0), 32'd1);
    end

    // 34 CONVERTs: ch 0..31 then 0,1, followed by two dummy reads
    do_reset();
    f0 = fd_cnt0;
    for (int k = 0; k < 36; k++) begin
      cmd = (k < 34) ? {2'b00, 6'(k % 32), 8'h00} : 16'hFF00;
      run_frame(cmd, 16, 8, 1'b1, w0);
      if (k >= 2)
        check($sformatf("convert word %0d", k), 32'(w0), 32'({6'((k - 2) % 32), ((k - 2) >= 32) ? 10'd1 : 10'd0}));
    end
    check("convert frame_done count", 32'(fd_cnt0 - f0), 32'd36);

    // 12-bit frame between valid frames is dropped
    do_reset();
    run_frame(16'hE800, 16, 8, 1'b1, w0);
    run_frame(16'hE900, 16, 8, 1'b1, w0);
    run_frame(16'h8123, 12, 8, 1'b1, w0);
    check("short frame last_cmd", 32'(lc0), 32'hE900);
`ifdef RHD_RESP_ERRCNT_EN
    check("short frame err_count", 32'(ec0), 32'd1);
`endif
    run_frame(16'hEA00, 16, 8, 1'b1, w0);
    check("after short frame miso", 32'(w0), 32'h0049);

    // SCLK at aclk/4 keeps decoding; delayed MISO still lags by exactly 3 aclk
    run_frame(16'hFF00, 16, 2, 1'b0, w0);
    run_frame(16'hFF00, 16, 2, 1'b0, w0);
    run_frame(16'hEB00, 16, 8, 1'b1, w0);
    check("fast frame readback", 32'(w0), 32'h0001);

    // reset in the middle of a frame after WRITE reg 0 = 0xDE
    run_frame(16'h80DE, 16, 8, 1'b1, w0);
    cs = 1'b0; cyc(8);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; sclk = 1'b1; cyc(8); sclk = 1'b0; cyc(8);
    end
    aresetn = 1'b0;
    cyc(2);
    check("midreset miso0", 32'(bus0.MISO), 32'd0);
    check("midreset miso3", 32'(bus3.MISO), 32'd0);
    check("midreset last_cmd", 32'(lc0), 32'd0);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cyc(2);
    aresetn = 1'b1;
    cyc(3);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      run_frame(16'hC000, 16, 8, 1'b1, w0);
      check($sformatf("post-reset read0 word %0d", k), 32'(w0), 32'd0);
    end

    // randomized frames against the reference model
    do_reset();
    for (int n = 0; n < 70; n++) begin
      int sel = int'($urandom_range(0, 9));
      int nb  = 16;
      int hf  = ($urandom_range(0, 9) == 0) ? 2 : 8;
      case (sel)
        0, 1:    cmd = {2'b00, ($urandom_range(0, 1) == 1) ? 6'd31 : 6'($urandom_range(0, 40)), 8'($urandom)};
        2, 3:    cmd = {2'b10, 6'($urandom_range(0, 30)), 8'($urandom)};
        4, 5, 6: cmd = {2'b11, 6'($urandom), 8'($urandom)};
        7:       cmd = ($urandom_range(0, 1) == 1) ? 16'h6A00 : 16'h5500;
        8:       cmd = {2'b01, 14'($urandom)};
        default: begin
          cmd = 16'($urandom);
          nb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
        end
      endcase
      run_frame(cmd, nb, hf, (hf == 8), w0);
    end
`ifdef RHD_RESP_ERRCNT_EN
    check("random err_count", 32'(ec0), 32'((m_aborts > 255) ? 255 : m_aborts));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
